// File: rtl/atp_bill_ctrl.sv
// atp_bill_ctrl: bill-payment controller for one transaction at a time.
// It handles cash notes, cheque, demand draft and prepaid debit. Features are change
// return, excess-to-prepaid credit, cancel/refund, inactivity timeout, a note-count
// limit and a settled-transaction counter.
//
// Ports:
//   clk, reset (async, active-low)       clock and reset; reset also clears prepaid balance
//   start, bill_amount, payment_method   open a transaction (IDLE only)
//   note_valid, cashmethod, invalid      cash note strobe, note code, counterfeit flag
//   direct_valid, direct_amount          cheque/DD strobe and face value
//   confirm, cancel                      customer completes / aborts
//   input_amount, updated_amount         amount accepted / remaining due
//   change_amount, prepaid_amount        cash change / persistent prepaid balance
//   refund_amount                        amount returned on cancel or timeout
//   bill_receipt, refund, note_reject    one-cycle event pulses
//   busy, txn_count                      not-IDLE flag / settled transaction count
module atp_bill_ctrl #(
   parameter int unsigned AMT_W       = 16,
   parameter int unsigned MAX_NOTES   = 16,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] bill_amount,
   input  logic [1:0]       payment_method,
   input  logic             note_valid,
   input  logic [2:0]       cashmethod,
   input  logic             invalid,
   input  logic             direct_valid,
   input  logic [AMT_W-1:0] direct_amount,
   input  logic             confirm,
   input  logic             cancel,
   output logic [AMT_W-1:0] input_amount,
   output logic [AMT_W-1:0] updated_amount,
   output logic [AMT_W-1:0] change_amount,
   output logic [AMT_W-1:0] prepaid_amount,
   output logic [AMT_W-1:0] refund_amount,
   output logic             bill_receipt,
   output logic             refund,
   output logic             note_reject,
   output logic             busy,
   output logic [CNT_W-1:0] txn_count
);

   localparam int unsigned NcW  = $clog2(MAX_NOTES + 1);
   localparam int unsigned TmW  = $clog2(TIMEOUT_CYC + 1);
   // Wide enough for any amount plus the largest note (500) without wrapping.
   localparam int unsigned SumW = ((AMT_W > 10) ? AMT_W : 10) + 1;
   localparam logic [SumW-1:0] AmtMax = SumW'({AMT_W{1'b1}});

   localparam logic [1:0] PmCash    = 2'b00;
   localparam logic [1:0] PmCheque  = 2'b01;
   localparam logic [1:0] PmDd      = 2'b10;
   localparam logic [1:0] PmPrepaid = 2'b11;

   typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

   state_e           state_q, state_d;
   logic [AMT_W-1:0] bill_q, bill_d;
   logic [1:0]       method_q, method_d;
   logic [AMT_W-1:0] input_q, input_d;
   logic [AMT_W-1:0] updated_q, updated_d;
   logic [AMT_W-1:0] change_q, change_d;
   logic [AMT_W-1:0] prepaid_q, prepaid_d;
   logic [AMT_W-1:0] refund_amt_q, refund_amt_d;
   logic [NcW-1:0]   note_cnt_q, note_cnt_d;
   logic [TmW-1:0]   timer_q, timer_d;
   logic             direct_done_q, direct_done_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic             receipt_q, receipt_d;
   logic             refund_q, refund_d;
   logic             reject_q, reject_d;

   logic [9:0]       denom;
   logic             denom_ok;
   logic [SumW-1:0]  cash_sum;
   logic             cash_accept;
   logic             direct_accept;
   logic             is_cash;
   logic             is_direct;
   logic             timed_out;
   logic             accepted;
   logic [AMT_W-1:0] excess;
   logic [AMT_W:0]   credit_sum;
   logic [AMT_W-1:0] credit;
   logic [AMT_W-1:0] debit;

   always_comb begin
      denom    = '0;
      denom_ok = 1'b1;
      case (cashmethod)
         3'b001:  denom = 10'd20;
         3'b010:  denom = 10'd50;
         3'b011:  denom = 10'd100;
         3'b100:  denom = 10'd200;
         3'b101:  denom = 10'd500;
         default: denom_ok = 1'b0;
      endcase
   end

   assign is_cash   = (method_q == PmCash);
   assign is_direct = (method_q == PmCheque) || (method_q == PmDd);
   assign timed_out = (timer_q == TmW'(TIMEOUT_CYC));

   assign cash_sum    = SumW'(input_q) + SumW'(denom);
   assign cash_accept = !invalid && denom_ok && (note_cnt_q < NcW'(MAX_NOTES)) &&
                        (cash_sum <= AmtMax);
   assign direct_accept = !invalid && !direct_done_q;

   // Excess is only consumed when input_q >= bill_q, so the subtraction never wraps in use.
   assign excess     = input_q - bill_q;
   assign credit_sum = {1'b0, prepaid_q} + {1'b0, excess};
   assign credit     = credit_sum[AMT_W] ? {AMT_W{1'b1}} : credit_sum[AMT_W-1:0];
   assign debit      = (prepaid_q < bill_q) ? prepaid_q : bill_q;

   always_comb begin
      state_d       = state_q;
      bill_d        = bill_q;
      method_d      = method_q;
      input_d       = input_q;
      updated_d     = updated_q;
      change_d      = change_q;
      prepaid_d     = prepaid_q;
      refund_amt_d  = refund_amt_q;
      note_cnt_d    = note_cnt_q;
      timer_d       = timer_q;
      direct_done_d = direct_done_q;
      txn_d         = txn_q;
      receipt_d     = 1'b0;
      refund_d      = 1'b0;
      reject_d      = 1'b0;
      accepted      = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d       = StCollect;
               bill_d        = bill_amount;
               method_d      = payment_method;
               input_d       = '0;
               updated_d     = bill_amount;
               change_d      = '0;
               refund_amt_d  = '0;
               note_cnt_d    = '0;
               timer_d       = '0;
               direct_done_d = 1'b0;
            end
         end

         StCollect: begin
            if (cancel || timed_out) begin
               refund_amt_d = input_q;
               input_d      = '0;
               updated_d    = bill_q;
               refund_d     = 1'b1;
               state_d      = StDone;
            end else if (confirm) begin
               if (method_q == PmPrepaid) begin
                  prepaid_d = prepaid_q - debit;
                  input_d   = debit;
                  updated_d = bill_q - debit;
               end else if (input_q >= bill_q) begin
                  updated_d = '0;
                  if (is_cash) begin
                     change_d = excess;
                  end else begin
                     prepaid_d = credit;
                  end
               end else begin
                  updated_d = bill_q - input_q;
               end
               receipt_d = 1'b1;
               txn_d     = txn_q + 1'b1;
               state_d   = StDone;
            end else begin
               if (is_cash && note_valid) begin
                  if (cash_accept) begin
                     input_d    = cash_sum[AMT_W-1:0];
                     note_cnt_d = note_cnt_q + 1'b1;
                     accepted   = 1'b1;
                  end else begin
                     reject_d = 1'b1;
                  end
               end else if (is_direct && direct_valid) begin
                  if (direct_accept) begin
                     input_d       = direct_amount;
                     direct_done_d = 1'b1;
                     accepted      = 1'b1;
                  end else begin
                     reject_d = 1'b1;
                  end
               end
               timer_d = accepted ? '0 : timer_q + 1'b1;
            end
         end

         StDone: state_d = StIdle;

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         bill_q        <= '0;
         method_q      <= '0;
         input_q       <= '0;
         updated_q     <= '0;
         change_q      <= '0;
         prepaid_q     <= '0;
         refund_amt_q  <= '0;
         note_cnt_q    <= '0;
         timer_q       <= '0;
         direct_done_q <= 1'b0;
         txn_q         <= '0;
         receipt_q     <= 1'b0;
         refund_q      <= 1'b0;
         reject_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         bill_q        <= bill_d;
         method_q      <= method_d;
         input_q       <= input_d;
         updated_q     <= updated_d;
         change_q      <= change_d;
         prepaid_q     <= prepaid_d;
         refund_amt_q  <= refund_amt_d;
         note_cnt_q    <= note_cnt_d;
         timer_q       <= timer_d;
         direct_done_q <= direct_done_d;
         txn_q         <= txn_d;
         receipt_q     <= receipt_d;
         refund_q      <= refund_d;
         reject_q      <= reject_d;
      end
   end

   assign input_amount   = input_q;
   assign updated_amount = updated_q;
   assign change_amount  = change_q;
   assign prepaid_amount = prepaid_q;
   assign refund_amount  = refund_amt_q;
   assign bill_receipt   = receipt_q;
   assign refund         = refund_q;
   assign note_reject    = reject_q;
   assign busy           = (state_q != StIdle);
   assign txn_count      = txn_q;

endmodule
